// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through data cache fence sequencing.
package wt_cache_pkg;

   typedef enum logic [2:0] {
      FENCE_IDLE,
      FENCE_STALL,
      FENCE_DRAIN,
      FENCE_FLUSH,
      FENCE_QUIESCE,
      FENCE_DONE
   } fence_state_e;

endpackage

// File: rtl/wt_dcache_fence_ctrl.sv
// Fence sequencer for the write-through data cache: stall, drain the write buffer,
// optionally flush, wait for idle, then pulse a single-cycle acknowledge.
module wt_dcache_fence_ctrl
   import wt_cache_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 4096,
   parameter int unsigned SettleCycles  = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic fence_req_i,
   input  logic fence_inval_i,
   output logic fence_ack_o,
   output logic fence_err_o,
   output logic fence_busy_o,
   output logic dcache_stall_o,
   output logic dcache_flush_o,
   input  logic dcache_flush_ack_i,
   input  logic dcache_wbuffer_empty_i,
   input  logic dcache_busy_i
);

   localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
   localparam int unsigned SetW = $clog2(SettleCycles + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
   localparam logic [TmoW-1:0] TmoMax  = TmoW'(TimeoutCycles);
   localparam logic [SetW-1:0] SetLast = SetW'(SettleCycles - 1);

   fence_state_e    r_state, w_state_next;
   logic [SetW-1:0] r_settle, w_settle_next;
   logic [TmoW-1:0] r_tmo, w_tmo_next;
   logic            r_inval, w_inval_next;
   logic            r_err, w_err_next;
   logic            w_tmo_hit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= FENCE_IDLE;
         r_settle <= '0;
         r_tmo    <= '0;
         r_inval  <= 1'b0;
         r_err    <= 1'b0;
      end else if (clr_i) begin
         r_state  <= FENCE_IDLE;
         r_settle <= '0;
         r_tmo    <= '0;
         r_inval  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_settle <= w_settle_next;
         r_tmo    <= w_tmo_next;
         r_inval  <= w_inval_next;
         r_err    <= w_err_next;
      end
   end

   // The current cycle is the last one allowed before an abort.
   assign w_tmo_hit = (r_tmo == TmoLast);

   always_comb begin
      w_state_next  = r_state;
      w_settle_next = r_settle;
      w_tmo_next    = r_tmo;
      w_inval_next  = r_inval;
      w_err_next    = r_err;
      case (r_state)
         FENCE_IDLE: begin
            if (fence_req_i) begin
               w_state_next = FENCE_STALL;
               w_inval_next = fence_inval_i;
               w_err_next   = 1'b0;
            end
         end
         FENCE_STALL: begin
            if (r_settle == SetLast) w_state_next = FENCE_DRAIN;
            else                     w_settle_next = r_settle + SetW'(1);
         end
         FENCE_DRAIN: begin
            if (dcache_wbuffer_empty_i) begin
               w_state_next = r_inval ? FENCE_FLUSH : FENCE_QUIESCE;
            end else if (w_tmo_hit) begin
               w_err_next   = 1'b1;
               w_state_next = FENCE_DONE;
            end
         end
         FENCE_FLUSH: begin
            if (dcache_flush_ack_i) w_state_next = FENCE_QUIESCE;
         end
         FENCE_QUIESCE: begin
            if (!dcache_busy_i) begin
               w_state_next = FENCE_DONE;
            end else if (w_tmo_hit) begin
               w_err_next   = 1'b1;
               w_state_next = FENCE_DONE;
            end
         end
         FENCE_DONE:    w_state_next = FENCE_IDLE;
         default:       w_state_next = FENCE_IDLE;
      endcase

      // Both counters restart on every state entry; the timeout one saturates.
      if (w_state_next != r_state) begin
         w_settle_next = '0;
         w_tmo_next    = '0;
      end else if ((r_state == FENCE_DRAIN || r_state == FENCE_QUIESCE) && r_tmo != TmoMax) begin
         w_tmo_next = r_tmo + TmoW'(1);
      end
   end

   assign fence_busy_o   = (r_state != FENCE_IDLE);
   assign dcache_stall_o = (r_state != FENCE_IDLE);
   assign dcache_flush_o = (r_state == FENCE_FLUSH);
   assign fence_ack_o    = (r_state == FENCE_DONE);
   assign fence_err_o    = (r_state == FENCE_DONE) && r_err;

endmodule

// File: doc/wt_dcache_fence_ctrl.md
# wt_dcache_fence_ctrl

Sequencer that drives the write-through data cache's stall, flush and busy handshakes on behalf of the core's fence / fence.t logic. On a fence request it stalls new memory requests, drains the write buffer, optionally flushes (invalidates) the cache, waits for the cache to go idle, and returns a single-cycle acknowledge, with an error flag if draining times out. It sits between the controller/commit stage and the data cache top level, and owns the cache's `stall_i` and `flush_i` inputs.

## Interface
Parameters:
- `TimeoutCycles`, default 4096: maximum cycles spent in DRAIN or QUIESCE before the fence is aborted with an error. Must be at least 1.
- `SettleCycles`, default 2: cycles the stall is held before draining is checked, so that in-flight accepts can land. Must be at least 1.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `clr_i` in 1: synchronous clear, active-high.
- `fence_req_i` in 1: fence request, level. Held until `fence_ack_o`.
- `fence_inval_i` in 1: also flush/invalidate the cache. Sampled with the request.
- `fence_ack_o` out 1: single-cycle completion pulse.
- `fence_err_o` out 1: valid with `fence_ack_o`. High means a timeout abort occurred.
- `fence_busy_o` out 1: high whenever state is not IDLE.
- `dcache_stall_o` out 1: connects to the cache `stall_i`.
- `dcache_flush_o` out 1: connects to the cache `flush_i`.
- `dcache_flush_ack_i` in 1: cache flush acknowledge.
- `dcache_wbuffer_empty_i` in 1: cache write buffer is empty.
- `dcache_busy_i` in 1: cache busy (controllers, miss unit, write buffer).

## Operation
States: IDLE, STALL, DRAIN, FLUSH, QUIESCE, DONE. All state and counters are registered.

Transitions:
- **IDLE -> STALL** when `fence_req_i`. Latch `fence_inval_i` into `inval_q` and clear `err_q`.
- **STALL**: `dcache_stall_o`=1. The settle counter counts SettleCycles cycles, then goes to DRAIN.
- **DRAIN**:
  - If `dcache_wbuffer_empty_i`, go to FLUSH when `inval_q`, otherwise to QUIESCE.
  - Else if the timeout counter reaches TimeoutCycles, set `err_q` and go to DONE.
- **FLUSH**: `dcache_flush_o`=1, held until `dcache_flush_ack_i` is sampled high, then go to QUIESCE.
  - No timeout applies, because the cache requires flush to be held until acknowledged.
- **QUIESCE**:
  - If `!dcache_busy_i`, go to DONE.
  - Else if the timeout is reached, set `err_q` and go to DONE.
- **DONE**: `fence_ack_o`=1 and `fence_err_o`=`err_q` for one cycle, then go to IDLE.

Output rules:
- `dcache_stall_o` is high in STALL, DRAIN, FLUSH, QUIESCE and DONE.
- The timeout counter is `$clog2(TimeoutCycles+1)` bits wide. It clears on every state entry, increments only in DRAIN and QUIESCE, and saturates.

## Timing
- **Reset** (`rst_i`, async): state IDLE, all counters and flags 0, every output 0.
- **`clr_i`**: same as reset, applied synchronously. It takes priority over every transition. An in-progress fence is dropped with no ack.
- **Minimum latency, no invalidate**: request sampled at cycle 0 → STALL cycles 1..S → DRAIN S+1 → QUIESCE S+2 → ack at cycle S+3.
- **`dcache_flush_ack_i`** is ignored outside FLUSH. An ack in the first FLUSH cycle is accepted.
- **`fence_req_i`**:
  - The requester must drop it in the ack cycle.
  - If it is high in the first IDLE cycle after DONE, a new fence starts.
  - Deasserting the request mid-sequence does not abort; completion still pulses ack.
- **`fence_inval_i`** changes after the request is sampled are ignored.
- **Timeout boundary**: if DRAIN/QUIESCE wait equals TimeoutCycles and the exit condition is true in the same cycle, the normal exit wins and there is no error.

## Structure
- `fence_state_e` (6-state enum) lives in `wt_cache_pkg`.
- Single module; no sub-module is warranted.
- Settle and timeout counters are inline.

## Test plan
- **Plain fence, all idle**: S=2, `wbuffer_empty`=1, `busy`=0, req at cycle 0. Required: ack and stall high at cycle 5, err=0, `flush_o` never high, stall low at cycle 6.
- **Invalidating fence**: `inval`=1, flush ack returned 1 cycle after `flush_o` rises. Required: `flush_o` high from cycle 4 exactly until the ack cycle (cycle 5), ack at cycle 7.
- **Drain wait**: `wbuffer_empty` held low for 10 cycles after STALL. Required: DRAIN persists, ack 2 cycles after empty rises, err=0.
- **Timeout**: TimeoutCycles=8, `wbuffer_empty` stuck 0. Required: ack with err=1 after exactly 8 DRAIN cycles; next fence starts with err cleared.
- **Clear mid-flush**: `clr_i` pulsed while `flush_o`=1. Required: next cycle IDLE, all outputs 0, no ack. A stray `dcache_flush_ack_i` afterwards is ignored.
- **Back-to-back**: req held high through ack. Required: second fence STALL begins 1 cycle after the first ack, `fence_busy_o` low for exactly that 1 IDLE cycle.
